// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the uart_tx_arb requester arbiter.
//   arb_state_e       : FSM states. The encodings are the values the older
//                       Verilog code used, so waveforms still line up.
//   TIMEOUT_CLKS_DFLT : default txack watchdog limit in clocks.
//   rr_wrap()         : round-robin successor index that wraps to 0 after
//                       n_req-1.
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SEND       = 2'd1,
        ST_WAIT_OWNER = 2'd2
    } arb_state_e;

    localparam int unsigned TIMEOUT_CLKS_DFLT = 65535;

    function automatic int unsigned rr_wrap(input int unsigned idx,
                                            input int unsigned n_req);
        return (idx + 1 >= n_req) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker.
//   req   : per-requester valid vector
//   ptr   : index where the search starts (highest priority)
//   found : at least one req bit is set
//   idx   : first set index at or after ptr, wrapping modulo N_REQ
module uart_rr_pick
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDXW  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDXW-1:0]  ptr,
    output logic             found,
    output logic [IDXW-1:0]  idx
);

    always_comb begin
        int unsigned cand;
        found = 1'b0;
        idx   = '0;
        cand  = 32'(ptr) % N_REQ;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = IDXW'(cand);
            end
            cand = rr_wrap(cand, N_REQ);
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_drv transmitter between N_REQ
// requesters, with multi-byte packet locking, back-to-back bytes and a txack
// watchdog.
//   clk, reset             : clock, synchronous active-high reset
//   req_valid/data/last    : per-requester byte offer (byte i at [8i+7:8i])
//   req_ready              : one-hot accept, combinational
//   txdata, txrdy, txack   : uart_drv handshake
//   busy                   : FSM not idle
//   owner                  : current or last granted requester
//   timeout_err            : sticky watchdog flag
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned IDXW         = 2,
    parameter int unsigned TIMEOUT_CLKS = TIMEOUT_CLKS_DFLT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*8-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         txdata,
    output logic               txrdy,
    input  logic               txack,
    output logic               busy,
    output logic [IDXW-1:0]    owner,
    output logic               timeout_err
);

    // Count never exceeds TIMEOUT_CLKS-1: that value either aborts or is
    // cleared by txack on the following edge.
    localparam int unsigned WDW     = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam int unsigned WD_LAST = (TIMEOUT_CLKS == 0) ? 0 : TIMEOUT_CLKS - 1;

    arb_state_e      state_q, state_d;
    logic [7:0]      txdata_q, txdata_d;
    logic            txrdy_q, txrdy_d;
    logic [IDXW-1:0] owner_q, owner_d;
    logic            lock_q, lock_d;
    logic [IDXW-1:0] rr_q, rr_d;
    logic [WDW-1:0]  wd_q, wd_d;
    logic            terr_q, terr_d;

    logic            pick_found;
    logic [IDXW-1:0] pick_idx;
    logic            acc_en;
    logic [IDXW-1:0] acc_idx;
    logic            wd_hit;

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .IDXW  (IDXW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        txdata_d  = txdata_q;
        txrdy_d   = txrdy_q;
        owner_d   = owner_q;
        lock_d    = lock_q;
        rr_d      = rr_q;
        wd_d      = wd_q;
        terr_d    = terr_q;
        req_ready = '0;
        acc_en    = 1'b0;
        acc_idx   = pick_idx;
        wd_hit    = (TIMEOUT_CLKS != 0) && (wd_q == WDW'(WD_LAST));

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    acc_en = 1'b1;
                end
            end
            ST_SEND: begin
                // txack takes priority over a watchdog expiry in the same cycle.
                if (txack) begin
                    wd_d = '0;
                    if (lock_q) begin
                        if (req_valid[owner_q]) begin
                            acc_en  = 1'b1;
                            acc_idx = owner_q;
                        end else begin
                            state_d = ST_WAIT_OWNER;
                            txrdy_d = 1'b0;
                        end
                    end else if (pick_found) begin
                        acc_en = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        txrdy_d = 1'b0;
                    end
                end else if (wd_hit) begin
                    terr_d  = 1'b1;
                    txrdy_d = 1'b0;
                    lock_d  = 1'b0;
                    rr_d    = IDXW'(rr_wrap(32'(owner_q), N_REQ));
                    wd_d    = '0;
                    state_d = ST_IDLE;
                end else if (TIMEOUT_CLKS != 0) begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            ST_WAIT_OWNER: begin
                // Only the packet owner may continue; everyone else waits.
                if (req_valid[owner_q]) begin
                    acc_en  = 1'b1;
                    acc_idx = owner_q;
                end else if (wd_hit) begin
                    terr_d  = 1'b1;
                    lock_d  = 1'b0;
                    rr_d    = IDXW'(rr_wrap(32'(owner_q), N_REQ));
                    wd_d    = '0;
                    state_d = ST_IDLE;
                end else if (TIMEOUT_CLKS != 0) begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                txrdy_d = 1'b0;
            end
        endcase

        if (acc_en) begin
            req_ready[acc_idx] = 1'b1;
            txdata_d = req_data[8*32'(acc_idx) +: 8];
            owner_d  = acc_idx;
            lock_d   = !req_last[acc_idx];
            txrdy_d  = 1'b1;
            wd_d     = '0;
            state_d  = ST_SEND;
            if (req_last[acc_idx]) begin
                rr_d = IDXW'(rr_wrap(32'(acc_idx), N_REQ));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            txdata_q <= '0;
            txrdy_q  <= 1'b0;
            owner_q  <= '0;
            lock_q   <= 1'b0;
            rr_q     <= '0;
            wd_q     <= '0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            txdata_q <= txdata_d;
            txrdy_q  <= txrdy_d;
            owner_q  <= owner_d;
            lock_q   <= lock_d;
            rr_q     <= rr_d;
            wd_q     <= wd_d;
            terr_q   <= terr_d;
        end
    end

    assign txdata      = txdata_q;
    assign txrdy       = txrdy_q;
    assign owner       = owner_q;
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed self-checking bench for uart_tx_arb with a small uart_drv model
// (each byte takes BYTE_CLKS clocks, txack on its last cycle).
module tb_uart_tx_arb;

    localparam int unsigned NR        = 4;
    localparam int unsigned IW        = 2;
    localparam int unsigned TO        = 100;
    localparam int unsigned BYTE_CLKS = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NR-1:0] req_valid;
    logic [NR*8-1:0] req_data;
    logic [NR-1:0] req_last;
    logic [NR-1:0] req_ready;
    logic [7:0]    txdata;
    logic          txrdy;
    logic          txack = 1'b0;
    logic          busy;
    logic [IW-1:0] owner;
    logic          timeout_err;

    always #5 clk = ~clk;

    uart_tx_arb #(
        .N_REQ        (NR),
        .IDXW         (IW),
        .TIMEOUT_CLKS (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .txdata      (txdata),
        .txrdy       (txrdy),
        .txack       (txack),
        .busy        (busy),
        .owner       (owner),
        .timeout_err (timeout_err)
    );

    // Requester tables: {last, data}; tpos advances on each transfer.
    logic [8:0]  tbl [NR][8];
    int unsigned tcnt [NR] = '{default: 0};
    int unsigned tpos [NR] = '{default: 0};
    logic [NR-1:0] rq_en = '1;
    logic [NR-1:0] take = '0;

    always_comb begin
        logic [8:0] e;
        e         = '0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int i = 0; i < NR; i++) begin
            if (rq_en[i] && tpos[i] < tcnt[i]) begin
                e = tbl[i][tpos[i] % 8];
                req_valid[i]      = 1'b1;
                req_data[8*i +: 8] = e[7:0];
                req_last[i]       = e[8];
            end
        end
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NR; i++) begin
            if (take[i]) tpos[i]++;
        end
    end

    // Transfer sampling and txrdy statistics, taken mid-low-phase.
    int   grant_q [$];
    int   rises = 0;
    int   high_cnt = 0;
    logic txrdy_prev = 1'b0;

    always @(negedge clk) begin
        #2;
        take = req_valid & req_ready;
        for (int i = 0; i < NR; i++) begin
            if (take[i]) grant_q.push_back(i);
        end
        if (txrdy === 1'b1 && txrdy_prev !== 1'b1) rises++;
        if (txrdy === 1'b1) high_cnt++;
        txrdy_prev = txrdy;
    end

    // uart_drv model: not reset by the arbiter reset.
    logic       drv_en = 1'b1;
    logic       drv_act = 1'b0;
    int         drv_cnt = 0;
    logic [7:0] drv_byte = '0;
    logic [7:0] wire_q [$];

    always @(negedge clk) begin
        txack = 1'b0;
        if (drv_act) begin
            drv_cnt++;
            if (drv_cnt == BYTE_CLKS) begin
                txack   = 1'b1;
                drv_act = 1'b0;
                wire_q.push_back(drv_byte);
            end
        end else if (drv_en && txrdy === 1'b1) begin
            drv_act  = 1'b1;
            drv_cnt  = 0;
            drv_byte = txdata;
        end
    end

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
        #1;
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic last);
        tbl[r][tcnt[r] % 8] = {last, d};
        tcnt[r]++;
    endtask

    task automatic wait_wire(input string tag, input int n, input int budget);
        int k = 0;
        while (wire_q.size() < n && k < budget) begin
            step(1);
            k++;
        end
        check_eq({tag, "_wire_wait"}, wire_q.size(), n);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        step(1);
        while ((busy !== 1'b0 || drv_act || req_valid != '0) && k < budget) begin
            step(1);
            k++;
        end
        check_eq({tag, "_idle"}, busy, 0);
    endtask

    // Expected grants packed 4 bits each, expected bytes packed 8 bits each.
    task automatic check_logs(input string tag, input int gb, input logic [31:0] exp_g, input int ng,
                              input int wb, input logic [63:0] exp_w, input int nw);
        logic [31:0] got;
        check_eq({tag, "_ngrant"}, grant_q.size() - gb, ng);
        for (int k = 0; k < ng; k++) begin
            got = (gb + k < grant_q.size()) ? grant_q[gb + k] : 32'hFFFF_FFFF;
            check_eq($sformatf("%s_grant%0d", tag, k), got, {28'd0, exp_g[4*k +: 4]});
        end
        check_eq({tag, "_nwire"}, wire_q.size() - wb, nw);
        for (int k = 0; k < nw; k++) begin
            got = (wb + k < wire_q.size()) ? {24'd0, wire_q[wb + k]} : 32'hFFFF_FFFF;
            check_eq($sformatf("%s_wire%0d", tag, k), got, {24'd0, exp_w[8*k +: 8]});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: sim time exceeded");
        $fatal(1, "timeout");
    end

    initial begin
        int gb, wb, r0, h0, ga;

        // Reset state
        reset = 1'b1;
        step(3);
        check_eq("rst_txrdy", txrdy, 0);
        check_eq("rst_txdata", txdata, 0);
        check_eq("rst_owner", owner, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_terr", timeout_err, 0);
        check_eq("rst_ready", req_ready, 0);
        reset = 1'b0;
        step(1);

        // Single byte from requester 2
        gb = grant_q.size(); wb = wire_q.size();
        push(2, 8'h41, 1'b1);
        #1;
        check_eq("t1_ready", req_ready, 4'b0100);
        step(1);
        check_eq("t1_txrdy", txrdy, 1);
        check_eq("t1_txdata", txdata, 8'h41);
        check_eq("t1_ready_pulse", req_ready, 0);
        check_eq("t1_busy", busy, 1);
        wait_idle("t1", 50);
        check_eq("t1_txrdy_end", txrdy, 0);
        check_eq("t1_owner", owner, 2);
        check_logs("t1", gb, 32'h2, 1, wb, 64'h41, 1);

        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);

        // Round-robin, all four valid, pointer 0, no idle gap
        gb = grant_q.size(); wb = wire_q.size(); r0 = rises; h0 = high_cnt;
        for (int i = 0; i < NR; i++) push(i, 8'h10 + 8'(i), 1'b1);
        wait_idle("t2", 100);
        check_eq("t2_rises", rises - r0, 1);
        check_eq("t2_high", high_cnt - h0, 20);
        check_logs("t2", gb, 32'h3210, 4, wb, 64'h13121110, 4);

        // Packet lock: req0 A0..A2 while req1 waits
        gb = grant_q.size(); wb = wire_q.size(); r0 = rises;
        push(0, 8'hA0, 1'b0); push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b1);
        push(1, 8'h51, 1'b1);
        wait_idle("t3", 100);
        check_eq("t3_rises", rises - r0, 1);
        check_logs("t3", gb, 32'h1000, 4, wb, 64'h51A2A1A0, 4);

        // Owner stall: req0 drops valid mid-packet, req1 blocked
        gb = grant_q.size(); wb = wire_q.size(); r0 = rises;
        push(0, 8'hB0, 1'b0);
        push(1, 8'h61, 1'b1);
        wait_wire("t4", wb + 1, 40);
        step(3);
        check_eq("t4_wait_txrdy", txrdy, 0);
        check_eq("t4_wait_busy", busy, 1);
        check_eq("t4_wait_ready", req_ready, 0);
        check_eq("t4_wait_owner", owner, 0);
        push(0, 8'hB1, 1'b1);
        step(1);
        check_eq("t4_resume_txrdy", txrdy, 1);
        check_eq("t4_resume_txdata", txdata, 8'hB1);
        wait_idle("t4", 100);
        check_eq("t4_rises", rises - r0, 2);
        check_logs("t4", gb, 32'h100, 3, wb, 64'h61B1B0, 3);

        // Watchdog: txack never comes
        gb = grant_q.size(); wb = wire_q.size();
        drv_en = 1'b0;
        h0 = high_cnt;
        push(3, 8'h77, 1'b1);
        begin
            int k = 0;
            step(2);
            while (busy !== 1'b0 && k < 300) begin
                step(1);
                k++;
            end
        end
        check_eq("t5_high", high_cnt - h0, TO);
        check_eq("t5_terr", timeout_err, 1);
        check_eq("t5_busy", busy, 0);
        check_eq("t5_txrdy", txrdy, 0);
        check_eq("t5_owner", owner, 3);
        drv_en = 1'b1;
        push(1, 8'h78, 1'b1);
        wait_idle("t5", 100);
        check_eq("t5_terr_sticky", timeout_err, 1);
        check_logs("t5", gb, 32'h13, 2, wb, 64'h78, 1);

        // Reset during the second byte of a packet
        gb = grant_q.size(); wb = wire_q.size();
        push(2, 8'hC0, 1'b0); push(2, 8'hC1, 1'b0); push(2, 8'hC2, 1'b1);
        wait_wire("t6", wb + 1, 40);
        step(2);
        rq_en[2] = 1'b0;
        reset = 1'b1;
        step(1);
        check_eq("t6_txrdy", txrdy, 0);
        check_eq("t6_busy", busy, 0);
        check_eq("t6_owner", owner, 0);
        check_eq("t6_terr", timeout_err, 0);
        check_eq("t6_txdata", txdata, 0);
        reset = 1'b0;
        ga = grant_q.size();
        wait_wire("t6_stray", wb + 2, 40);
        step(3);
        check_eq("t6_no_grant", grant_q.size(), ga);
        check_eq("t6_busy_after", busy, 0);
        check_eq("t6_txrdy_after", txrdy, 0);
        check_logs("t6", gb, 32'h22, 2, wb, 64'hC1C0, 2);
        gb = grant_q.size(); wb = wire_q.size();
        push(1, 8'h91, 1'b1);
        wait_idle("t6b", 100);
        check_logs("t6b", gb, 32'h1, 1, wb, 64'h91, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
